// File: rtl/reg_file_multiport.sv
// ============================================================================
//  Module      : reg_file_multiport
//  Description : Two-write-port register file with a pending (scoreboard) bit
//                per register, reserve port and RD_PORTS combinational reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   wrEn,
    input  logic [2*ADDR_W-1:0]          wrAddr,
    input  logic [2*DATA_W-1:0]          wrData,
    input  logic                         rsvEn,
    input  logic [ADDR_W-1:0]            rsvAddr,
    input  logic [RD_PORTS*ADDR_W-1:0]   rdAddr,
    output logic [RD_PORTS*DATA_W-1:0]   rdData,
    output logic [RD_PORTS-1:0]          rdPending
);

    localparam int c_NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [c_NUM_REGS];
    logic [DATA_W-1:0] regs_d [c_NUM_REGS];
    logic              pend_q [c_NUM_REGS];
    logic              pend_d [c_NUM_REGS];

    logic [ADDR_W-1:0] w_wr_addr [2];
    logic [DATA_W-1:0] w_wr_data [2];
    logic [1:0]        w_wr_hit;

    for (genvar k = 0; k < 2; k++) begin : g_wr
        assign w_wr_addr[k] = wrAddr[k*ADDR_W +: ADDR_W];
        assign w_wr_data[k] = wrData[k*DATA_W +: DATA_W];
        assign w_wr_hit[k]  = wrEn[k] && (w_wr_addr[k] != '0);
    end

    // Port 1 is applied after port 0 so it wins a same-address collision;
    // the reserve is applied last so it wins over the write's pending clear.
    always_comb begin
        for (int i = 0; i < c_NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            pend_d[i] = pend_q[i];
        end
        for (int k = 0; k < 2; k++) begin
            if (w_wr_hit[k]) begin
                regs_d[w_wr_addr[k]] = w_wr_data[k];
                pend_d[w_wr_addr[k]] = 1'b0;
            end
        end
        if (rsvEn && (rsvAddr != '0)) begin
            pend_d[rsvAddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
                pend_q[i] <= pend_d[i];
            end
        end
    end

    for (genvar j = 0; j < RD_PORTS; j++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_data;
        logic              w_pend;

        assign w_ra = rdAddr[j*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = regs_q[w_ra];
            w_pend = pend_q[w_ra];
            if (BYPASS != 0) begin
                for (int k = 0; k < 2; k++) begin
                    if (wrEn[k] && (w_wr_addr[k] == w_ra)) begin
                        w_data = w_wr_data[k];
                        w_pend = 1'b0;
                    end
                end
            end
            // Gating on rst keeps outputs zero even before the async clear settles.
            if ((w_ra == '0) || !rst) begin
                w_data = '0;
                w_pend = 1'b0;
            end
        end

        assign rdData[j*DATA_W +: DATA_W] = w_data;
        assign rdPending[j]               = w_pend;
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_multiport.sv
// ============================================================================
//  Module      : tb_reg_file_multiport
//  Description : Directed and random checks of reg_file_multiport against a
//                behavioural array model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk;
    logic          rst;
    logic [1:0]    wrEn;
    logic [2*AW-1:0] wrAddr;
    logic [2*DW-1:0] wrData;
    logic          rsvEn;
    logic [AW-1:0] rsvAddr;
    logic [2*AW-1:0] rdAddr;
    logic [2*DW-1:0] rdData;
    logic [1:0]    rdPending;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_mem  [NR];
    logic          m_pend [NR];

    reg_file_multiport #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .rsvEn(rsvEn), .rsvAddr(rsvAddr), .rdAddr(rdAddr),
        .rdData(rdData), .rdPending(rdPending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Expected read value: what a reader sees this cycle, with bypass.
    function automatic logic [DW:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        logic          p;
        if (!rst || a == 0) return '0;
        d = m_mem[a];
        p = m_pend[a];
        if (wrEn[1] && wrAddr[AW +: AW] == a) begin
            d = wrData[DW +: DW]; p = 1'b0;
        end else if (wrEn[0] && wrAddr[0 +: AW] == a) begin
            d = wrData[0 +: DW]; p = 1'b0;
        end
        return {p, d};
    endfunction

    task automatic model_edge();
        logic [AW-1:0] a0, a1;
        if (!rst) return;
        a0 = wrAddr[0 +: AW];
        a1 = wrAddr[AW +: AW];
        if (wrEn[0] && a0 != 0) begin m_mem[a0] = wrData[0 +: DW];  m_pend[a0] = 1'b0; end
        if (wrEn[1] && a1 != 0) begin m_mem[a1] = wrData[DW +: DW]; m_pend[a1] = 1'b0; end
        if (rsvEn && rsvAddr != 0) m_pend[rsvAddr] = 1'b1;
    endtask

    task automatic check_reads(input string tag);
        logic [DW:0] e;
        for (int j = 0; j < 2; j++) begin
            e = model_read(rdAddr[j*AW +: AW]);
            n_assert++;
            assert (rdData[j*DW +: DW] === e[DW-1:0]) else begin
                n_fail++;
                $error("FAIL %s rdData[%0d] addr=%0d observed=%h expected=%h",
                       tag, j, rdAddr[j*AW +: AW], rdData[j*DW +: DW], e[DW-1:0]);
            end
            n_assert++;
            assert (rdPending[j] === e[DW]) else begin
                n_fail++;
                $error("FAIL %s rdPending[%0d] addr=%0d observed=%b expected=%b",
                       tag, j, rdAddr[j*AW +: AW], rdPending[j], e[DW]);
            end
        end
    endtask

    task automatic set_in(input logic [1:0] we, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input logic rv, input logic [AW-1:0] ra,
                          input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        wrEn    = we;
        wrAddr  = {a1, a0};
        wrData  = {d1, d0};
        rsvEn   = rv;
        rsvAddr = ra;
        rdAddr  = {r1, r0};
    endtask

    // Inputs are already applied: settle, check, clock, update model.
    task automatic cycle(input string tag);
        #1;
        check_reads(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, NR-1));
    endfunction

    initial begin
        rst = 1'b0;
        model_clear();
        // Reset held: inputs are active but outputs must read zero and writes drop.
        set_in(2'b11, 5'd3, 32'h1234_5678, 5'd4, 32'h9ABC_DEF0, 1'b1, 5'd3, 5'd3, 5'd4);
        cycle("in_reset");
        cycle("in_reset2");
        rst = 1'b1;
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd3, 5'd4);
        cycle("after_release");

        for (int a = 0; a < NR; a++) begin
            set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, AW'(a), AW'(NR-1-a));
            cycle("reset_sweep");
        end

        set_in(2'b00, 0, 0, 0, 0, 1'b1, 5'd5, 5'd5, 5'd5);
        cycle("rsv_r5");
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd5, 5'd6);
        #1; n_assert++;
        assert (rdPending[0] === 1'b1) else begin
            n_fail++; $error("FAIL r5_pending observed=%b expected=1", rdPending[0]);
        end
        cycle("r5_pending");
        set_in(2'b01, 5'd5, 32'hDEAD_BEEF, 0, 0, 1'b0, 0, 5'd5, 5'd5);
        #1; n_assert++;
        assert (rdData[DW-1:0] === 32'hDEAD_BEEF && rdPending[0] === 1'b0) else begin
            n_fail++; $error("FAIL r5_bypass observed=%h/%b expected=deadbeef/0", rdData[DW-1:0], rdPending[0]);
        end
        cycle("r5_bypass");
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd5, 5'd0);
        cycle("r5_stored");

        set_in(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 0, 5'd7, 5'd1);
        cycle("r7_collide");
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd7, 5'd7);
        #1; n_assert++;
        assert (rdData[DW +: DW] === 32'h22) else begin
            n_fail++; $error("FAIL r7_port1_wins observed=%h expected=22", rdData[DW +: DW]);
        end
        cycle("r7_after");

        set_in(2'b01, 5'd9, 32'h55, 0, 0, 1'b1, 5'd9, 5'd2, 5'd3);
        cycle("r9_rsv_wr");
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd9, 5'd9);
        #1; n_assert++;
        assert (rdData[DW-1:0] === 32'h55 && rdPending[0] === 1'b1) else begin
            n_fail++; $error("FAIL r9_rsv_wins observed=%h/%b expected=55/1", rdData[DW-1:0], rdPending[0]);
        end
        cycle("r9_after");

        set_in(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        cycle("r0_write");
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd0, 5'd0);
        cycle("r0_after");

        // Reserve already-pending register: stays pending, nothing else changes.
        set_in(2'b00, 0, 0, 0, 0, 1'b1, 5'd9, 5'd9, 5'd5);
        cycle("r9_rerserve");
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd9, 5'd5);
        cycle("r9_still");

        for (int n = 0; n < 400; n++) begin
            set_in(2'($urandom_range(0, 3)), rnd_addr(), $urandom, rnd_addr(), $urandom,
                   1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr());
            cycle("random");
        end

        // Mid-operation asynchronous reset, pulsed entirely between edges.
        set_in(2'b01, 5'd4, 32'hAB, 0, 0, 1'b1, 5'd3, 5'd3, 5'd4);
        cycle("pre_reset");
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd3, 5'd4);
        #1;
        rst = 1'b0;
        model_clear();
        #1;
        check_reads("async_reset");
        n_assert++;
        assert (rdData === '0 && rdPending === '0) else begin
            n_fail++; $error("FAIL async_zero observed=%h/%b expected=0/0", rdData, rdPending);
        end
        #1;
        rst = 1'b1;
        cycle("post_reset");
        set_in(2'b10, 0, 0, 5'd3, 32'h77, 1'b1, 5'd4, 5'd3, 5'd4);
        cycle("post_reset_op");
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd3, 5'd4);
        cycle("post_reset_check");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
